// File: rtl/midi_tone_io.sv
// Monophonic MIDI note-on/off parser driving a square-wave tone on SPEAKER.
// Byte strobe and data are synchronised from an asynchronous source into CLK_24MHZ.
module midi_tone_io #(
  parameter bit          OMNI    = 1'b1,
  parameter logic [3:0]  CHANNEL = 4'hC,
  parameter int unsigned CLK_HZ  = 24000000
) (
  input  logic       CLK_24MHZ,
  input  logic       RST_N,
  input  logic       EXT_CLK,
  input  logic [7:0] data_pins_i,
  output logic       SPEAKER
);

  // The half-period table is fixed for a 24 MHz clock; CLK_HZ is descriptive only.
  if (CLK_HZ == 0) begin : g_clk_hz_info
  end

  logic [1:0]  ext_s_q;
  logic        ext_prev_q;
  logic [7:0]  dat_s1_q, dat_s2_q;

  logic [7:0]  status_q;
  logic        rs_q;
  logic        pend_q;
  logic [6:0]  d1_q;

  logic [6:0]  note_q;
  logic        active_q;
  logic [20:0] cnt_q;
  logic        spk_q;

  logic        strobe;
  logic [7:0]  rx;
  logic        need_one, ch_ok, complete, on_evt, off_evt;

  logic [14:0] prod;
  logic [3:0]  oct;
  logic [6:0]  oct12, rem;
  logic [10:0] base;
  logic [20:0] hp, hp_m1;

  assign strobe  = ext_s_q[1] & ~ext_prev_q;
  assign rx      = dat_s2_q;
  assign SPEAKER = spk_q;

  always_comb begin
    need_one = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
    ch_ok    = OMNI || (status_q[3:0] == CHANNEL);
    complete = strobe && !rx[7] && rs_q && (need_one || pend_q);
    on_evt   = complete && ch_ok && (status_q[7:4] == 4'h9) && (rx[6:0] != 7'd0);
    off_evt  = complete && ch_ok && active_q && (d1_q == note_q) &&
               ((status_q[7:4] == 4'h8) ||
                ((status_q[7:4] == 4'h9) && (rx[6:0] == 7'd0)));
  end

  // note/12 via multiply-by-reciprocal (171/2048), exact for 0..127
  always_comb begin
    prod  = {8'd0, note_q} * 15'd171;
    oct   = prod[14:11];
    oct12 = {oct, 3'b000} + {1'b0, oct, 2'b00};
    rem   = note_q - oct12;
    case (rem[3:0])
      4'd0:    base = 11'd1433;
      4'd1:    base = 11'd1353;
      4'd2:    base = 11'd1277;
      4'd3:    base = 11'd1205;
      4'd4:    base = 11'd1138;
      4'd5:    base = 11'd1074;
      4'd6:    base = 11'd1014;
      4'd7:    base = 11'd957;
      4'd8:    base = 11'd903;
      4'd9:    base = 11'd852;
      4'd10:   base = 11'd804;
      4'd11:   base = 11'd759;
      default: base = 11'd0;
    endcase
    hp    = {10'd0, base} << (4'd10 - oct);
    hp_m1 = hp - 21'd1;
  end

  always_ff @(posedge CLK_24MHZ or negedge RST_N) begin
    if (!RST_N) begin
      ext_s_q    <= '0;
      ext_prev_q <= 1'b0;
      dat_s1_q   <= '0;
      dat_s2_q   <= '0;
    end else begin
      ext_s_q    <= {ext_s_q[0], EXT_CLK};
      ext_prev_q <= ext_s_q[1];
      dat_s1_q   <= data_pins_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  always_ff @(posedge CLK_24MHZ or negedge RST_N) begin
    if (!RST_N) begin
      status_q <= '0;
      rs_q     <= 1'b0;
      pend_q   <= 1'b0;
      d1_q     <= '0;
    end else if (strobe) begin
      if (rx[7:3] == 5'b11111) begin
        rs_q <= rs_q;
      end else if (rx[7:4] == 4'hF) begin
        rs_q   <= 1'b0;
        pend_q <= 1'b0;
      end else if (rx[7]) begin
        status_q <= rx;
        rs_q     <= 1'b1;
        pend_q   <= 1'b0;
      end else if (rs_q) begin
        if (complete) begin
          pend_q <= 1'b0;
        end else begin
          pend_q <= 1'b1;
          d1_q   <= rx[6:0];
        end
      end
    end
  end

  always_ff @(posedge CLK_24MHZ or negedge RST_N) begin
    if (!RST_N) begin
      note_q   <= '0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      spk_q    <= 1'b0;
    end else if (on_evt) begin
      note_q   <= d1_q;
      active_q <= 1'b1;
      cnt_q    <= '0;
      spk_q    <= 1'b0;
    end else if (off_evt || !active_q) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      spk_q    <= 1'b0;
    end else if (cnt_q == hp_m1) begin
      cnt_q <= '0;
      spk_q <= ~spk_q;
    end else begin
      cnt_q <= cnt_q + 21'd1;
    end
  end

endmodule

// File: tb/tb_midi_tone_io.sv
// Randomised bench for midi_tone_io: a message-level MIDI model predicts tone
// state, SPEAKER timing is measured against the note half-period formula.
module tb_midi_tone_io;
  logic       clk = 1'b0, rst_n = 1'b0, ext = 1'b0;
  logic [7:0] din = 8'h00;
  logic       spk;
  int         checks = 0, errors = 0;
  logic       spk_at5 = 1'b0;
  int         last_hold = 4;

  midi_tone_io #(.OMNI(1'b0), .CHANNEL(4'hC), .CLK_HZ(24000000)) dut (
    .CLK_24MHZ(clk), .RST_N(rst_n), .EXT_CLK(ext), .data_pins_i(din), .SPEAKER(spk));

  always #5 clk = ~clk;

  // Reference model: message-level view of the parser and tone state
  logic [7:0] m_status;
  bit         m_rs, m_active, m_restart;
  logic [6:0] m_note;
  logic [6:0] m_pend[$];
  int         base_tab[12] = '{1433, 1353, 1277, 1205, 1138, 1074, 1014, 957, 903, 852, 804, 759};

  function automatic int exp_hp(input int n);
    return base_tab[n % 12] << (10 - n / 12);
  endfunction

  function automatic void model_reset();
    m_rs = 0; m_active = 0; m_restart = 0; m_note = 0; m_status = 0;
    m_pend.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int need;
    m_restart = 0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin m_rs = 0; m_pend.delete(); return; end
    if (b[7]) begin m_status = b; m_rs = 1; m_pend.delete(); return; end
    if (!m_rs) return;
    m_pend.push_back(b[6:0]);
    need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
    if (m_pend.size() == need) begin
      if (m_status[3:0] == 4'hC) begin
        if (m_status[7:4] == 4'h9 && m_pend[1] != 0) begin
          m_note = m_pend[0]; m_active = 1; m_restart = 1;
        end else if ((m_status[7:4] == 4'h8 || m_status[7:4] == 4'h9) &&
                     m_pend[0] == m_note && m_active) begin
          m_active = 0;
        end
      end
      m_pend.delete();
    end
  endfunction

  task automatic strobe(input logic [7:0] b, input int hold = 4);
    @(negedge clk); din = b; ext = 1'b1;
    for (int i = 1; i <= 2 * hold; i++) begin
      @(negedge clk);
      if (i == 5) spk_at5 = spk;
      if (i == hold) ext = 1'b0;
    end
    last_hold = hold;
    model_byte(b);
  endtask

  task automatic wait_spk(input logic v, input int budget, output int n);
    n = 0;
    while (spk !== v && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic check_silent(input string name, input int cyc);
    int bad = 0;
    for (int i = 0; i < cyc; i++) begin @(negedge clk); if (spk !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s: speaker high %0d cycles, required 0", name, bad); end
  endtask

  // Compare SPEAKER against what the model says should be sounding now
  task automatic check_tone(input string name);
    int hp, n, total;
    logic v;
    if (!m_active) begin check_silent(name, 600); return; end
    hp = exp_hp(m_note);
    if (m_restart) begin
      if (hp > 40000) begin check_silent(name, 2000); return; end
      wait_spk(1'b1, hp + 20, n);
      total = 2 * last_hold + n;
      checks++;
      if (spk !== 1'b1 || total < hp + 3 || total > hp + 5) begin
        errors++;
        $display("FAIL %s first toggle: %0d cycles after strobe, required %0d..%0d", name, total, hp + 3, hp + 5);
      end
    end
    if (hp <= 5000) begin
      v = spk; wait_spk(~v, 2 * hp + 20, n);
      v = spk; wait_spk(~v, hp + 20, n);
      checks++;
      if (n != hp) begin
        errors++;
        $display("FAIL %s half-period: got %0d, required %0d", name, n, hp);
      end
    end
  endtask

  task automatic check_at5(input string name);
    checks++;
    if (spk_at5 !== 1'b0) begin
      errors++;
      $display("FAIL %s: speaker %b 5 cycles after strobe, required 0", name, spk_at5);
    end
  endtask

  task automatic raise_spk(input string name);
    int n;
    wait_spk(1'b1, 3000, n);
    checks++;
    if (spk !== 1'b1) begin errors++; $display("FAIL %s: speaker never high, required 1", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (spk !== 1'b0) begin errors++; $display("FAIL reset: speaker %b, required 0", spk); end
    rst_n = 1'b1;
    strobe(8'h50); strobe(8'h7F);
    check_tone("no_status");
  endtask

  task automatic test_basic();
    strobe(8'h9C); strobe(8'h50); strobe(8'h7F);
    check_at5("basic_restart");
    check_tone("basic_note80");
  endtask

  task automatic test_running_status();
    for (int r = 0; r < 3; r++) begin
      strobe(8'h9C, 12); strobe(8'h7F, 12); strobe(8'h7F, 12); strobe(8'h00, 12);
    end
    strobe(8'h9C, 12); strobe(8'h7F, 12); strobe(8'h7F, 12);
    check_tone("running_status");
  endtask

  task automatic test_note_off();
    strobe(8'h9C); strobe(8'h7F); strobe(8'h7F);
    raise_spk("off_setup1");
    strobe(8'h8C); strobe(8'h7F); strobe(8'h00);
    check_at5("note_off_8x");
    check_tone("note_off_8x_silent");
    strobe(8'h9C); strobe(8'h7F); strobe(8'h7F);
    raise_spk("off_setup2");
    strobe(8'h9C); strobe(8'h7F); strobe(8'h00);
    check_at5("note_off_vel0");
    check_tone("note_off_vel0_silent");
    strobe(8'h9C); strobe(8'h7F); strobe(8'h7F);
    strobe(8'h8C); strobe(8'h45); strobe(8'h00);
    check_tone("off_other_note");
  endtask

  task automatic test_extremes();
    strobe(8'h9C); strobe(8'h45); strobe(8'h40);
    check_tone("note69");
    strobe(8'h9C); strobe(8'h7F); strobe(8'h01);
    check_tone("note127");
    strobe(8'h9C); strobe(8'h00); strobe(8'h7F);
    check_tone("note0");
    strobe(8'h8C); strobe(8'h00); strobe(8'h00);
    check_tone("note0_off");
  endtask

  task automatic test_channel_noise();
    strobe(8'h93); strobe(8'h50); strobe(8'h7F);
    check_tone("other_channel");
    strobe(8'h9C); strobe(8'hF8); strobe(8'h7F); strobe(8'h7F);
    check_tone("realtime_inserted");
  endtask

  task automatic test_reset_mid_tone();
    raise_spk("reset_setup");
    @(negedge clk); rst_n = 1'b0; #1;
    checks++;
    if (spk !== 1'b0) begin errors++; $display("FAIL reset_async: speaker %b, required 0", spk); end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    strobe(8'h50); strobe(8'h7F);
    check_tone("after_reset_no_status");
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [6:0] nt;
    for (int it = 0; it < 3; it++) begin
      for (int m = 0; m < 4; m++) begin
        q.delete();
        nt = ($urandom_range(0, 2) == 0 && m_active) ? m_note : 7'($urandom_range(118, 127));
        case ($urandom_range(0, 6))
          0: begin q.push_back(8'h9C); q.push_back({1'b0, nt}); q.push_back(8'($urandom_range(1, 127))); end
          1: begin q.push_back(8'h8C); q.push_back({1'b0, nt}); q.push_back(8'($urandom_range(0, 127))); end
          2: begin q.push_back(8'h9C); q.push_back({1'b0, nt}); q.push_back(8'h00); end
          3: begin q.push_back(8'h93); q.push_back({1'b0, nt}); q.push_back(8'h7F); end
          4: begin q.push_back(8'h9C); q.push_back({1'b0, nt}); q.push_back(8'hF0); q.push_back(8'h7F); end
          5: begin q.push_back(8'hCC); q.push_back(8'($urandom_range(0, 127))); q.push_back({1'b0, nt}); end
          default: begin q.push_back(8'h9C); q.push_back({1'b0, nt}); q.push_back(8'hF8); q.push_back(8'h50); end
        endcase
        foreach (q[k]) strobe(q[k]);
      end
      check_tone("random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_running_status();
    test_note_off();
    test_extremes();
    test_channel_noise();
    test_reset_mid_tone();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
